// File: rtl/md5_digit_cracker.sv
`timescale 1ns/1ps
// MD5 brute-force search over fixed-length decimal-digit passwords.
// One MD5 round per clock; BCD candidates step by STRIDE until a digest match or wrap past all nines.
module md5_digit_cracker #(
   parameter int unsigned N_DIGITS = 8,
   parameter int unsigned STRIDE   = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [4*N_DIGITS-1:0] start_val,
   input  logic [127:0]          target,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  found,
   output logic                  exhausted,
   output logic [4*N_DIGITS-1:0] match_val,
   output logic [127:0]          hash,
   output logic [31:0]           cand_cnt
);
   localparam int unsigned W = 4*N_DIGITS;
   localparam logic [31:0] A0 = 32'h67452301;
   localparam logic [31:0] B0 = 32'hefcdab89;
   localparam logic [31:0] C0 = 32'h98badcfe;
   localparam logic [31:0] D0 = 32'h10325476;

   localparam logic [31:0] K [64] = '{
      32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
      32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
      32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
      32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
      32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
      32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
      32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
      32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
      32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
      32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
      32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
      32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
      32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
      32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
      32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
      32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
   };

   // Indexed by {round group, i mod 4}.
   localparam logic [4:0] SH [16] = '{
      5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9,  5'd14, 5'd20,
      5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
   };

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_FINAL, S_CHECK} state_t;

   state_t         state_q;
   logic [W-1:0]   cand_q, cand_d, match_q;
   logic [127:0]   target_q, hash_q;
   logic [31:0]    a_q, b_q, c_q, d_q, b_d, cnt_q;
   logic [5:0]     i_q;
   logic           done_q, found_q, exh_q, ovf_d;
   logic [511:0]   msg;
   logic [31:0]    func, mword, sum, rot;
   logic [3:0]     g, ii;
   logic [4:0]     sh;
   logic [4:0]     dsum;
   logic [3:0]     cy;

   function automatic logic [31:0] bswap(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   // The message block is a pure function of the current candidate, which only changes in CHECK.
   always_comb begin
      msg = '0;
      for (int unsigned j = 0; j < N_DIGITS; j++)
         msg[8*j +: 8] = 8'h30 + {4'h0, cand_q[4*(N_DIGITS-1-j) +: 4]};
      msg[8*N_DIGITS +: 8] = 8'h80;
      msg[448 +: 32]       = 32'(8*N_DIGITS);
   end

   always_comb begin
      ii   = i_q[3:0];
      func = '0;
      g    = '0;
      case (i_q[5:4])
         2'd0: begin func = (b_q & c_q) | (~b_q & d_q); g = ii;                end
         2'd1: begin func = (d_q & b_q) | (~d_q & c_q); g = ii * 4'd5 + 4'd1;  end
         2'd2: begin func = b_q ^ c_q ^ d_q;            g = ii * 4'd3 + 4'd5;  end
         default: begin func = c_q ^ (b_q | ~d_q);      g = ii * 4'd7;         end
      endcase
      sh    = SH[{i_q[5:4], i_q[1:0]}];
      mword = msg[{g, 5'd0} +: 32];
      sum   = a_q + func + K[i_q] + mword;
      rot   = (sum << sh) | (sum >> (6'd32 - {1'b0, sh}));
      b_d   = b_q + rot;
   end

   // Ripple BCD add of STRIDE; a carry out of the top digit means the space is exhausted.
   always_comb begin
      cand_d = cand_q;
      cy     = 4'(STRIDE);
      dsum   = '0;
      for (int unsigned n = 0; n < N_DIGITS; n++) begin
         dsum = {1'b0, cand_q[4*n +: 4]} + {1'b0, cy};
         if (dsum > 5'd9) begin
            cand_d[4*n +: 4] = 4'(dsum - 5'd10);
            cy               = 4'd1;
         end else begin
            cand_d[4*n +: 4] = dsum[3:0];
            cy               = 4'd0;
         end
      end
      ovf_d = (cy != 4'd0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cand_q   <= '0;
         match_q  <= '0;
         target_q <= '0;
         hash_q   <= '0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         d_q      <= '0;
         cnt_q    <= '0;
         i_q      <= '0;
         done_q   <= 1'b0;
         found_q  <= 1'b0;
         exh_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort) begin
            state_q <= S_IDLE;
         end else begin
            case (state_q)
               S_IDLE: if (start) begin
                  cand_q   <= start_val;
                  target_q <= target;
                  found_q  <= 1'b0;
                  exh_q    <= 1'b0;
                  cnt_q    <= '0;
                  state_q  <= S_LOAD;
               end
               S_LOAD: begin
                  a_q     <= A0;
                  b_q     <= B0;
                  c_q     <= C0;
                  d_q     <= D0;
                  i_q     <= '0;
                  state_q <= S_ROUND;
               end
               S_ROUND: begin
                  a_q <= d_q;
                  b_q <= b_d;
                  c_q <= b_q;
                  d_q <= c_q;
                  i_q <= i_q + 6'd1;
                  if (i_q == 6'd63) state_q <= S_FINAL;
               end
               S_FINAL: begin
                  hash_q  <= {bswap(a_q + A0), bswap(b_q + B0), bswap(c_q + C0), bswap(d_q + D0)};
                  state_q <= S_CHECK;
               end
               S_CHECK: begin
                  if (cnt_q != '1) cnt_q <= cnt_q + 32'd1;
                  if (hash_q == target_q) begin
                     found_q <= 1'b1;
                     match_q <= cand_q;
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end else if (ovf_d) begin
                     exh_q   <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end else begin
                     cand_q  <= cand_d;
                     state_q <= S_LOAD;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign found     = found_q;
   assign exhausted = exh_q;
   assign match_val = match_q;
   assign hash      = hash_q;
   assign cand_cnt  = cnt_q;
endmodule

// File: tb/tb_md5_digit_cracker.sv
`timescale 1ns/1ps
// Bench for md5_digit_cracker: an 8-digit stride-1 and a 4-digit stride-2 instance,
// checked against a loop-based MD5 model and decimal arithmetic.
module tb_md5_digit_cracker;
   logic clk = 1'b0;
   logic rst_n;

   logic a_start, a_abort, a_busy, a_done, a_found, a_exh;
   logic [31:0]  a_val, a_match, a_cnt;
   logic [127:0] a_tgt, a_hash;
   logic b_start, b_abort, b_busy, b_done, b_found, b_exh;
   logic [15:0]  b_val, b_match;
   logic [31:0]  b_cnt;
   logic [127:0] b_tgt, b_hash;

   int checks = 0;
   int errors = 0;

   localparam int SHT [16] = '{7,12,17,22, 5,9,14,20, 4,11,16,23, 6,10,15,21};

   md5_digit_cracker #(.N_DIGITS(8), .STRIDE(1)) u_dut8 (
      .clk(clk), .reset_n(rst_n), .start(a_start), .start_val(a_val), .target(a_tgt),
      .abort(a_abort), .busy(a_busy), .done(a_done), .found(a_found), .exhausted(a_exh),
      .match_val(a_match), .hash(a_hash), .cand_cnt(a_cnt));

   md5_digit_cracker #(.N_DIGITS(4), .STRIDE(2)) u_dut4 (
      .clk(clk), .reset_n(rst_n), .start(b_start), .start_val(b_val), .target(b_tgt),
      .abort(b_abort), .busy(b_busy), .done(b_done), .found(b_found), .exhausted(b_exh),
      .match_val(b_match), .hash(b_hash), .cand_cnt(b_cnt));

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] kconst(input int i);
      real r;
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      return 32'(longint'($floor(r * 4294967296.0)));
   endfunction

   // MD5 of the n-digit zero-padded decimal string of v.
   function automatic logic [127:0] md5_ref(input int n, input longint unsigned v);
      logic [7:0]   by [64];
      logic [31:0]  m [16];
      logic [31:0]  r [4];
      logic [31:0]  a, b, c, d, f, t;
      logic [127:0] h;
      int g, s;
      for (int j = 0; j < 64; j++) by[j] = 8'h00;
      for (int j = n - 1; j >= 0; j--) begin
         by[j] = 8'(48 + v % 10);
         v = v / 10;
      end
      by[n]  = 8'h80;
      by[56] = 8'(8 * n);
      for (int k = 0; k < 16; k++) m[k] = {by[4*k+3], by[4*k+2], by[4*k+1], by[4*k]};
      a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
      for (int i = 0; i < 64; i++) begin
         case (i / 16)
            0: begin f = (b & c) | (~b & d); g = i;                end
            1: begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
            2: begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
            default: begin f = c ^ (b | ~d); g = (7 * i) % 16;     end
         endcase
         s = SHT[(i / 16) * 4 + i % 4];
         t = a + f + kconst(i) + m[g];
         t = (t << s) | (t >> (32 - s));
         a = d; d = c; c = b; b = b + t;
      end
      r[0] = a + 32'h67452301; r[1] = b + 32'hefcdab89;
      r[2] = c + 32'h98badcfe; r[3] = d + 32'h10325476;
      h = '0;
      for (int w = 0; w < 4; w++)
         for (int k = 0; k < 4; k++)
            h[127 - 8*(4*w + k) -: 8] = r[w][8*k +: 8];
      return h;
   endfunction

   function automatic logic [63:0] to_bcd(input longint unsigned v);
      logic [63:0] x;
      for (int k = 0; k < 16; k++) begin
         x[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return x;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Launch a search on one instance and count cycles until done (bounded).
   // lat = cycle index of done relative to the accepting edge T (done in cycle T+lat).
   task automatic run(input bit sel4, input logic [31:0] v, input logic [127:0] t,
                      input int bound, output int lat);
      if (sel4) begin b_val = v[15:0]; b_tgt = t; b_start = 1'b1; end
      else      begin a_val = v;       a_tgt = t; a_start = 1'b1; end
      @(posedge clk); #1;
      a_start = 1'b0; b_start = 1'b0;
      lat = 1;
      while (!(sel4 ? b_done : a_done) && lat < bound) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      a_start = 0; a_abort = 0; a_val = '0; a_tgt = '0;
      b_start = 0; b_abort = 0; b_val = '0; b_tgt = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", a_busy); end
      checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", a_done); end
      checks++; if ({a_found, a_exh} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {a_found, a_exh}); end
      checks++; if (a_match !== 32'h0) begin errors++; $display("FAIL reset_match got %h want 0", a_match); end
      checks++; if (a_hash !== 128'h0) begin errors++; $display("FAIL reset_hash got %h want 0", a_hash); end
      checks++; if (a_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt got %0d want 0", a_cnt); end
      checks++; if ({b_busy, b_done, b_found, b_exh, b_cnt} !== 36'h0) begin errors++; $display("FAIL reset_dut4 got %h want 0", {b_busy, b_done, b_found, b_exh, b_cnt}); end
   endtask

   task automatic test_known_match();
      int lat;
      run(1'b0, 32'h12345670, 128'h25d55ad283aa400af464c76d713c07ad, 700, lat);
      checks++; if (lat !== 604) begin errors++; $display("FAIL known_latency got %0d want 604", lat); end
      checks++; if (a_found !== 1'b1 || a_exh !== 1'b0) begin errors++; $display("FAIL known_flags got %b%b want 10", a_found, a_exh); end
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL known_busy got %b want 0", a_busy); end
      checks++; if (a_match !== 32'h12345678) begin errors++; $display("FAIL known_match got %h want 12345678", a_match); end
      checks++; if (a_cnt !== 32'd9) begin errors++; $display("FAIL known_cnt got %0d want 9", a_cnt); end
      checks++; if (a_hash !== md5_ref(8, 12345678)) begin errors++; $display("FAIL known_hash got %h want %h", a_hash, md5_ref(8, 12345678)); end
      @(posedge clk); #1;
      checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL known_done_pulse got %b want 0", a_done); end
   endtask

   task automatic test_immediate();
      int lat;
      run(1'b0, 32'h00000000, 128'hdd4b21e9ef71e1291183a46b913ae6f2, 200, lat);
      checks++; if (lat !== 68) begin errors++; $display("FAIL imm_latency got %0d want 68", lat); end
      checks++; if (a_hash !== 128'hdd4b21e9ef71e1291183a46b913ae6f2) begin errors++; $display("FAIL imm_hash got %h want dd4b21e9ef71e1291183a46b913ae6f2", a_hash); end
      checks++; if (a_cnt !== 32'd1 || a_found !== 1'b1) begin errors++; $display("FAIL imm_cnt_found got %0d/%b want 1/1", a_cnt, a_found); end
      @(posedge clk); #1;
   endtask

   task automatic test_stride();
      int lat;
      run(1'b1, 32'h1230, 128'h81dc9bdb52d04dc20036dbd8313ed055, 400, lat);
      checks++; if (lat !== 202) begin errors++; $display("FAIL stride_latency got %0d want 202", lat); end
      checks++; if (b_match !== 16'h1234) begin errors++; $display("FAIL stride_match got %h want 1234", b_match); end
      checks++; if (b_cnt !== 32'd3 || b_found !== 1'b1) begin errors++; $display("FAIL stride_cnt_found got %0d/%b want 3/1", b_cnt, b_found); end
      @(posedge clk); #1;
   endtask

   task automatic test_exhaust();
      int lat;
      run(1'b1, 32'h9991, rnd128(), 600, lat);
      checks++; if (lat !== 336) begin errors++; $display("FAIL exh4_latency got %0d want 336", lat); end
      checks++; if (b_exh !== 1'b1 || b_found !== 1'b0) begin errors++; $display("FAIL exh4_flags got exh=%b found=%b want 1/0", b_exh, b_found); end
      checks++; if (b_cnt !== 32'd5) begin errors++; $display("FAIL exh4_cnt got %0d want 5", b_cnt); end
      checks++; if (b_hash !== md5_ref(4, 9999)) begin errors++; $display("FAIL exh4_hash got %h want %h", b_hash, md5_ref(4, 9999)); end
      checks++; if (b_match !== 16'h1234) begin errors++; $display("FAIL exh4_match_hold got %h want 1234", b_match); end
      @(posedge clk); #1;
      run(1'b0, 32'h99999998, rnd128(), 300, lat);
      checks++; if (lat !== 135) begin errors++; $display("FAIL exh8_latency got %0d want 135", lat); end
      checks++; if (a_exh !== 1'b1 || a_found !== 1'b0 || a_cnt !== 32'd2) begin errors++; $display("FAIL exh8_state got exh=%b found=%b cnt=%0d want 1/0/2", a_exh, a_found, a_cnt); end
      @(posedge clk); #1;
   endtask

   task automatic test_abort();
      int lat;
      int seen;
      a_val = 32'h00000100; a_tgt = rnd128(); a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      repeat (140) begin @(posedge clk); #1; end
      checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b want 1", a_busy); end
      a_abort = 1'b1;
      @(posedge clk); #1;
      a_abort = 1'b0;
      checks++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b done=%b want 0/0", a_busy, a_done); end
      checks++; if (a_cnt !== 32'd2) begin errors++; $display("FAIL abort_cnt got %0d want 2", a_cnt); end
      checks++; if (a_found !== 1'b0 || a_exh !== 1'b0) begin errors++; $display("FAIL abort_flags got %b%b want 00", a_found, a_exh); end
      seen = 0;
      repeat (80) begin @(posedge clk); #1; if (a_done || a_busy) seen++; end
      checks++; if (seen !== 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles want 0", seen); end
      run(1'b0, 32'h00000000, md5_ref(8, 0), 200, lat);
      checks++; if (lat !== 68 || a_found !== 1'b1 || a_cnt !== 32'd1) begin errors++; $display("FAIL abort_restart got lat=%0d found=%b cnt=%0d want 68/1/1", lat, a_found, a_cnt); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int lat1, lat2;
      run(1'b0, 32'h00000003, md5_ref(8, 4), 300, lat1);
      run(1'b0, 32'h00000005, md5_ref(8, 5), 200, lat2);
      checks++; if (lat1 !== 135) begin errors++; $display("FAIL b2b_first_latency got %0d want 135", lat1); end
      checks++; if (lat2 !== 68) begin errors++; $display("FAIL b2b_second_latency got %0d want 68", lat2); end
      checks++; if (a_match !== 32'h00000005 || a_cnt !== 32'd1) begin errors++; $display("FAIL b2b_result got %h/%0d want 00000005/1", a_match, a_cnt); end
      checks++; if (a_hash !== md5_ref(8, 5)) begin errors++; $display("FAIL b2b_hash got %h want %h", a_hash, md5_ref(8, 5)); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      a_val = 32'h00000000; a_tgt = md5_ref(8, 3); a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      repeat (50) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      checks++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b/%b want 0/0", a_busy, a_done); end
      checks++; if (a_hash !== 128'h0) begin errors++; $display("FAIL rstmid_hash got %h want 0", a_hash); end
      checks++; if (a_match !== 32'h0) begin errors++; $display("FAIL rstmid_match got %h want 0", a_match); end
      checks++; if (a_found !== 1'b0 || a_exh !== 1'b0 || a_cnt !== 32'h0) begin errors++; $display("FAIL rstmid_state got %b%b/%0d want 00/0", a_found, a_exh, a_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_start_ignored();
      int lat;
      a_val = 32'h00000000; a_tgt = md5_ref(8, 2); a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      lat = 1;
      repeat (20) begin @(posedge clk); #1; lat++; end
      a_val = 32'h55555555; a_tgt = rnd128(); a_start = 1'b1;
      @(posedge clk); #1; lat++;
      a_start = 1'b0;
      while (!a_done && lat < 400) begin @(posedge clk); #1; lat++; end
      checks++; if (lat !== 202) begin errors++; $display("FAIL ignored_latency got %0d want 202", lat); end
      checks++; if (a_match !== 32'h00000002 || a_cnt !== 32'd3) begin errors++; $display("FAIL ignored_result got %h/%0d want 00000002/3", a_match, a_cnt); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int lat;
      longint unsigned base, hit;
      int k;
      logic [63:0] bcd;
      for (int it = 0; it < 4; it++) begin
         base = longint'($urandom_range(99999995, 0));
         k    = int'($urandom_range(4, 0));
         hit  = base + longint'(k);
         bcd  = to_bcd(base);
         run(1'b0, bcd[31:0], md5_ref(8, hit), 67 * (k + 1) + 20, lat);
         bcd  = to_bcd(hit);
         checks++; if (lat !== 1 + 67 * (k + 1)) begin errors++; $display("FAIL rand8_latency it=%0d got %0d want %0d", it, lat, 1 + 67 * (k + 1)); end
         checks++; if (a_match !== bcd[31:0] || a_found !== 1'b1) begin errors++; $display("FAIL rand8_match it=%0d got %h want %h", it, a_match, bcd[31:0]); end
         checks++; if (a_cnt !== 32'(k + 1)) begin errors++; $display("FAIL rand8_cnt it=%0d got %0d want %0d", it, a_cnt, k + 1); end
         @(posedge clk); #1;
      end
      for (int it = 0; it < 4; it++) begin
         base = longint'($urandom_range(9991, 0));
         k    = int'($urandom_range(3, 0));
         hit  = base + longint'(2 * k);
         bcd  = to_bcd(base);
         run(1'b1, {16'h0, bcd[15:0]}, md5_ref(4, hit), 67 * (k + 1) + 20, lat);
         bcd  = to_bcd(hit);
         checks++; if (lat !== 1 + 67 * (k + 1)) begin errors++; $display("FAIL rand4_latency it=%0d got %0d want %0d", it, lat, 1 + 67 * (k + 1)); end
         checks++; if (b_match !== bcd[15:0] || b_found !== 1'b1) begin errors++; $display("FAIL rand4_match it=%0d got %h want %h", it, b_match, bcd[15:0]); end
         checks++; if (b_hash !== md5_ref(4, hit)) begin errors++; $display("FAIL rand4_hash it=%0d got %h want %h", it, b_hash, md5_ref(4, hit)); end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_known_match();
      test_immediate();
      test_stride();
      test_exhaust();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      test_start_ignored();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
